// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: op codes, default sizes,
// requester indices and the result-buffer state type.
package alu_share_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_OPW   = 3;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SHL    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_UNUSED = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b100;
    localparam logic [2:0] ALU_SHR    = 3'b101;
    localparam logic [2:0] ALU_OR     = 3'b110;
    localparam logic [2:0] ALU_AND    = 3'b111;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational ALU shared by both requesters; add/sub wrap and
// shifts use only the low log2(WIDTH) bits of b.
module alu_core
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OPW   = DEFAULT_OPW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt_s;

    assign shamt_s = b[SHW-1:0];

    // Op decode; the unused code yields zero
    always_comb begin
        result = {WIDTH{1'b0}};
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SHL:    result = a << shamt_s;
            ALU_SUB:    result = a - b;
            ALU_XOR:    result = a ^ b;
            ALU_SHR:    result = a >> shamt_s;
            ALU_OR:     result = a | b;
            ALU_AND:    result = a & b;
            ALU_UNUSED: result = {WIDTH{1'b0}};
            default:    result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, with a
// single registered result buffer carrying owner, zero and sign flags.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OPW   = DEFAULT_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_sign,
    output logic             res_owner
);

    buf_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;
    logic             owner_q, owner_d;

    logic             can_accept_s;
    logic             grant0_s, grant1_s, accept_s;
    logic [OPW-1:0]   sel_op_s;
    logic [WIDTH-1:0] sel_a_s, sel_b_s, alu_res_s;

    assign can_accept_s = (state_q == BUF_EMPTY) | res_ready;

    // Grant: lone requester wins, contention resolved by the pointer
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (can_accept_s) begin
            if (req0_valid && req1_valid) begin
                grant0_s = (ptr_q == REQ0);
                grant1_s = (ptr_q == REQ1);
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign sel_op_s   = grant1_s ? req1_op : req0_op;
    assign sel_a_s    = grant1_s ? req1_a  : req0_a;
    assign sel_b_s    = grant1_s ? req1_b  : req0_b;

    alu_core #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .a      (sel_a_s),
        .b      (sel_b_s),
        .op     (sel_op_s),
        .result (alu_res_s)
    );

    // Next buffer state: accept fills, drain without accept empties
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: state_d = accept_s ? BUF_FULL : BUF_EMPTY;
            BUF_FULL: begin
                if (accept_s) begin
                    state_d = BUF_FULL;
                end else if (res_ready) begin
                    state_d = BUF_EMPTY;
                end else begin
                    state_d = BUF_FULL;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // Payload and pointer load only on accept, otherwise hold
    always_comb begin
        data_d  = data_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept_s) begin
            data_d  = alu_res_s;
            zero_d  = (alu_res_s == {WIDTH{1'b0}});
            sign_d  = alu_res_s[WIDTH-1];
            owner_d = grant1_s ? REQ1 : REQ0;
            ptr_d   = grant1_s ? REQ0 : REQ1;
        end else begin
            data_d  = data_q;
            ptr_d   = ptr_q;
        end
    end

    // State, payload and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            ptr_q   <= REQ0;
            data_q  <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            owner_q <= REQ0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        res_valid = (state_q == BUF_FULL);
        res_data  = data_q;
        res_zero  = zero_q;
        res_sign  = sign_q;
        res_owner = owner_q;
    end

endmodule
